// File: rtl/nav_pkg.sv
// Shared types and helpers for the navigation speed controller.
// Saturating speed arithmetic is done at 12 bits and clamped into the 11-bit speed.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDNG     = 3'd1,
    RAMP_UP  = 3'd2,
    DEC      = 3'd3,
    DEC_FAST = 3'd4
  } nav_state_t;

  localparam int DEC_MULT      = 2;
  localparam int DEC_FAST_MULT = 4;

  function automatic logic [10:0] sat_add(input logic [10:0] spd,
                                          input logic [10:0] inc,
                                          input logic [10:0] ceil);
    logic [11:0] sum;
    sum = {1'b0, spd} + {1'b0, inc};
    return (sum > {1'b0, ceil}) ? ceil : sum[10:0];
  endfunction

  function automatic logic [10:0] sat_sub(input logic [10:0] spd,
                                          input logic [11:0] step);
    logic [11:0] ext;
    ext = {1'b0, spd};
    return (ext < step) ? 11'd0 : 11'(ext - step);
  endfunction

endpackage

// File: rtl/nav_rise_det.sv
// Single-flop rising-edge detector. The history flop resets to 1 so a level
// already high when reset releases is never reported as an edge.
module nav_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/nav_spd_ctrl.sv
// Navigation sequencer feeding the heading PID: heading changes plus forward moves
// with a strobe-timed speed ramp. Optional heading timeout enabled by NAV_HDNG_TMO_EN.
module nav_spd_ctrl
  import nav_pkg::*;
#(
  parameter logic [10:0] MIN_FRWRD = 11'h0D0,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter logic [10:0] FRWRD_INC = 11'h018,
  parameter logic [19:0] HDNG_TMO  = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_vld,
  input  logic        at_hdng,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        moving,
  output logic        en_fusion,
  output logic [10:0] frwrd_spd,
  output logic        mv_cmplt,
  output logic        hdng_err
);

  localparam logic [11:0] DEC_STEP      = 12'(DEC_MULT) * {1'b0, FRWRD_INC};
  localparam logic [11:0] DEC_FAST_STEP = 12'(DEC_FAST_MULT) * {1'b0, FRWRD_INC};
  localparam logic [10:0] FUSION_THR    = MAX_FRWRD >> 1;

  nav_state_t  state_q, state_d;
  logic [10:0] spd_q, spd_d;
  logic        moving_q, mv_cmplt_q, mv_cmplt_d, en_fusion_q;
  logic        lft_rise, rght_rise, stop_req;
  logic        tmo_hit, hdng_err_d;

  nav_rise_det u_lft_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (lft_opn),
    .rise_o(lft_rise)
  );

  nav_rise_det u_rght_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (rght_opn),
    .rise_o(rght_rise)
  );

  assign stop_req = (stp_lft && lft_rise) || (stp_rght && rght_rise);

`ifdef NAV_HDNG_TMO_EN
  logic [19:0] tmo_cnt_q;
  logic        hdng_err_q;

  assign tmo_hit = ((tmo_cnt_q + 20'd1) == HDNG_TMO);

  // Counter sits at zero outside HDNG, so it starts fresh on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      hdng_err_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= (state_q == HDNG && state_d == HDNG) ? tmo_cnt_q + 20'd1 : '0;
      hdng_err_q <= hdng_err_d;
    end
  end

  assign hdng_err = hdng_err_q;
`else
  assign tmo_hit  = 1'b0;
  assign hdng_err = 1'b0;
`endif

  // Next-state and speed datapath: ramp on strobes, decelerate on stop or obstacle.
  always_comb begin
    state_d    = state_q;
    spd_d      = spd_q;
    mv_cmplt_d = 1'b0;
    hdng_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        spd_d = '0;
        if (strt_hdng) begin
          state_d = HDNG;
        end else if (strt_mv) begin
          state_d = RAMP_UP;
          spd_d   = MIN_FRWRD;
        end
      end
      HDNG: begin
        spd_d = '0;
        if (at_hdng && hdng_vld) begin
          state_d    = IDLE;
          mv_cmplt_d = 1'b1;
        end else if (tmo_hit) begin
          state_d    = IDLE;
          hdng_err_d = 1'b1;
        end
      end
      RAMP_UP: begin
        if (hdng_vld) spd_d = sat_add(spd_q, FRWRD_INC, MAX_FRWRD);
        if (!frwrd_opn)    state_d = DEC_FAST;
        else if (stop_req) state_d = DEC;
      end
      DEC: begin
        if (spd_q == '0) begin
          state_d    = IDLE;
          mv_cmplt_d = 1'b1;
        end else begin
          if (hdng_vld)   spd_d   = sat_sub(spd_q, DEC_STEP);
          if (!frwrd_opn) state_d = DEC_FAST;
        end
      end
      DEC_FAST: begin
        if (spd_q == '0) begin
          state_d    = IDLE;
          mv_cmplt_d = 1'b1;
        end else if (hdng_vld) begin
          spd_d = sat_sub(spd_q, DEC_FAST_STEP);
        end
      end
      default: begin
        state_d = IDLE;
        spd_d   = '0;
      end
    endcase
  end

  // State, speed and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      spd_q       <= '0;
      moving_q    <= 1'b0;
      mv_cmplt_q  <= 1'b0;
      en_fusion_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      spd_q       <= spd_d;
      moving_q    <= (state_d != IDLE);
      mv_cmplt_q  <= mv_cmplt_d;
      en_fusion_q <= (spd_d > FUSION_THR);
    end
  end

  assign moving    = moving_q;
  assign frwrd_spd = spd_q;
  assign mv_cmplt  = mv_cmplt_q;
  assign en_fusion = en_fusion_q;

endmodule

// File: tb/tb_nav_spd_ctrl.sv
// Directed-plus-random bench for nav_spd_ctrl; expected speeds come from ramp/decel
// arithmetic on strobe counts. Build with NAV_HDNG_TMO_EN to exercise the timeout.
module tb_nav_spd_ctrl;

  localparam int MIN_SPD = 'h0D0;
  localparam int MAX_SPD = 'h2A0;
  localparam int INC     = 'h018;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_hdng = 1'b0, strt_mv = 1'b0, stp_lft = 1'b0, stp_rght = 1'b0;
  logic        hdng_vld = 1'b0, at_hdng = 1'b0;
  logic        lft_opn = 1'b0, rght_opn = 1'b0, frwrd_opn = 1'b1;
  logic        moving, en_fusion, mv_cmplt, hdng_err;
  logic [10:0] frwrd_spd;

  int compared   = 0;
  int mismatched = 0;
  int expSpd     = 0;
  int step       = 0;
  int cycles     = 0;
  logic sawErr   = 1'b0;

  always #5 clk = ~clk;

  nav_spd_ctrl #(.HDNG_TMO(20'd100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_hdng(strt_hdng),
    .strt_mv  (strt_mv),
    .stp_lft  (stp_lft),
    .stp_rght (stp_rght),
    .hdng_vld (hdng_vld),
    .at_hdng  (at_hdng),
    .lft_opn  (lft_opn),
    .rght_opn (rght_opn),
    .frwrd_opn(frwrd_opn),
    .moving   (moving),
    .en_fusion(en_fusion),
    .frwrd_spd(frwrd_spd),
    .mv_cmplt (mv_cmplt),
    .hdng_err (hdng_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic hdng, input logic mv, input logic vld);
    strt_hdng = hdng;
    strt_mv   = mv;
    hdng_vld  = vld;
    tick();
    strt_hdng = 1'b0;
    strt_mv   = 1'b0;
    hdng_vld  = 1'b0;
  endtask

  task automatic checkSpeed(input string tag);
    checkOutput(tag, 32'(frwrd_spd), expSpd);
    checkOutput({tag, "_fusion"}, 32'(en_fusion), 32'(expSpd > MAX_SPD / 2));
  endtask

  // Random idle clocks between strobes; speed must hold, at_hdng is noise here.
  task automatic idleGap(input string tag);
    int n;
    n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      at_hdng = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(tag, 32'(frwrd_spd), expSpd);
    end
    at_hdng = 1'b0;
  endtask

  task automatic checkCompletion(input string tag);
    checkOutput({tag, "_early"}, 32'(mv_cmplt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_cmplt"}, 32'(mv_cmplt), 32'd1);
    checkOutput({tag, "_moving"}, 32'(moving), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_pulse"}, 32'(mv_cmplt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with the left opening already present.
    lft_opn = 1'b1;
    #12;
    checkOutput("rst_moving", 32'(moving), 32'd0);
    checkOutput("rst_spd", 32'(frwrd_spd), 32'd0);
    checkOutput("rst_cmplt", 32'(mv_cmplt), 32'd0);
    checkOutput("rst_err", 32'(hdng_err), 32'd0);
    checkOutput("rst_fusion", 32'(en_fusion), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] heading change");
    expSpd = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hdng_moving", 32'(moving), 32'd1);
    for (int k = 0; k < 5; k++) begin
      idleGap("hdng_gap");
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hdng_wait_moving", 32'(moving), 32'd1);
      checkOutput("hdng_wait_cmplt", 32'(mv_cmplt), 32'd0);
      checkOutput("hdng_wait_spd", 32'(frwrd_spd), 32'd0);
    end
    at_hdng = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hdng_no_vld", 32'(moving), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    at_hdng = 1'b0;
    checkOutput("hdng_cmplt", 32'(mv_cmplt), 32'd1);
    checkOutput("hdng_moving_fall", 32'(moving), 32'd0);
    checkOutput("hdng_spd", 32'(frwrd_spd), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hdng_pulse", 32'(mv_cmplt), 32'd0);

    $display("[TB] ramp up, opening present since reset");
    stp_lft = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expSpd = MIN_SPD;
    checkSpeed("mv_start");
    checkOutput("mv_moving", 32'(moving), 32'd1);
    for (int n = 1; n <= 25; n++) begin
      idleGap("ramp_gap");
      if (n == 8) begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkSpeed("ramp_hdng_ignored");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkSpeed("ramp_mv_ignored");
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      expSpd = (MIN_SPD + n * INC > MAX_SPD) ? MAX_SPD : MIN_SPD + n * INC;
      checkSpeed("ramp");
      if (n == 19) checkOutput("ramp_pre_clamp", 32'(frwrd_spd), 32'h298);
      if (n == 20) checkOutput("ramp_clamp20", 32'(frwrd_spd), 32'h2A0);
    end
    checkOutput("ramp_moving", 32'(moving), 32'd1);

    $display("[TB] left opening stop, escalating to fast decel");
    lft_opn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkSpeed("lft_fall");
    lft_opn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkSpeed("lft_rise");
    step = 2 * INC;
    for (int k = 1; k <= 30 && expSpd > 0; k++) begin
      idleGap("dec_gap");
      if (k == 4) begin
        frwrd_opn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkSpeed("dec_escalate");
        step = 4 * INC;
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      expSpd = (expSpd > step) ? expSpd - step : 0;
      checkSpeed("dec");
    end
    checkCompletion("dec_done");
    frwrd_opn = 1'b1;
    stp_lft   = 1'b0;

    $display("[TB] obstacle beats right-opening stop");
    stp_rght = 1'b1;
    lft_opn  = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expSpd = MIN_SPD;
    checkSpeed("mv2_start");
    for (int n = 1; n <= 6; n++) begin
      idleGap("ramp2_gap");
      if (n == 3) lft_opn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      expSpd = MIN_SPD + n * INC;
      checkSpeed("ramp2");
    end
    checkOutput("ramp2_at_160", 32'(frwrd_spd), 32'h160);
    frwrd_opn = 1'b0;
    rght_opn  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkSpeed("fast_entry");
    step = 4 * INC;
    for (int k = 1; k <= 10 && expSpd > 0; k++) begin
      idleGap("fast_gap");
      applyStimulus(1'b0, 1'b0, 1'b1);
      expSpd = (expSpd > step) ? expSpd - step : 0;
      checkSpeed("fast");
    end
    checkCompletion("fast_done");
    frwrd_opn = 1'b1;
    stp_rght  = 1'b0;

    $display("[TB] simultaneous start commands");
    expSpd = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_moving", 32'(moving), 32'd1);
    checkSpeed("both_spd");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkSpeed("both_hold");
    at_hdng = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    at_hdng = 1'b0;
    checkOutput("both_cmplt", 32'(mv_cmplt), 32'd1);
    checkOutput("both_moving_fall", 32'(moving), 32'd0);

    $display("[TB] reset mid-ramp");
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 10; n++) applyStimulus(1'b0, 1'b0, 1'b1);
    expSpd = MIN_SPD + 10 * INC;
    checkSpeed("pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_spd", 32'(frwrd_spd), 32'd0);
    checkOutput("arst_moving", 32'(moving), 32'd0);
    checkOutput("arst_fusion", 32'(en_fusion), 32'd0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("post_rst_cmplt", 32'(mv_cmplt), 32'd0);
      checkOutput("post_rst_moving", 32'(moving), 32'd0);
      checkOutput("post_rst_spd", 32'(frwrd_spd), 32'd0);
    end

`ifdef NAV_HDNG_TMO_EN
    $display("[TB] heading timeout");
    at_hdng = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    cycles = 0;
    while (hdng_err !== 1'b1 && cycles < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      cycles++;
    end
    checkOutput("tmo_cycles", 32'(cycles), 32'd100);
    checkOutput("tmo_no_cmplt", 32'(mv_cmplt), 32'd0);
    checkOutput("tmo_moving", 32'(moving), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("tmo_err_pulse", 32'(hdng_err), 32'd0);
`else
    $display("[TB] heading waits without timeout");
    at_hdng = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    sawErr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (hdng_err !== 1'b0) sawErr = 1'b1;
    end
    checkOutput("wait_no_err", 32'(sawErr), 32'd0);
    checkOutput("wait_moving", 32'(moving), 32'd1);
    at_hdng = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    at_hdng = 1'b0;
    checkOutput("wait_cmplt", 32'(mv_cmplt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
